// File: rtl/arbiter_8_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_8_ctrl_if
// Description : Request/grant bundle between eight clients and arbiter_8_ctrl.
//               Signals:
//                 req[7:0]    client request lines (client -> arbiter)
//                 done        release strobe from the current owner
//                 gnt[7:0]    one-hot registered grant (arbiter -> clients)
//                 gnt_id[2:0] binary owner index, valid while busy=1
//                 busy        a grant is active
//                 timeout     one-cycle pulse when the hold limit revokes a grant
//               Modports: master = client side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_8_ctrl_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output busy,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/arbiter_8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_8_ctrl
// Description : Sequential 8-requester arbiter. The winner is registered and
//               held until it releases (done, or its request drops) or the
//               hold limit expires; one dead GAP cycle then precedes the next
//               arbitration. Non-owners never preempt the current grant.
// Parameters  : HOLD_MAX - maximum grant length in cycles (1..15)
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - arbiter_8_ctrl_if.slave (req, done in;
//                       gnt, gnt_id, busy, timeout out)
// Build macro : ROUND_ROBIN_EN - when defined, rotating priority (search
//               starts just below the last winner, wrapping 0 -> 7, last
//               winner checked last). When undefined, the highest requesting
//               index always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_8_ctrl #(
  parameter int HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  arbiter_8_ctrl_if.slave    bus
);

  localparam logic [3:0] C_HOLD_MAX = 4'(HOLD_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e     state_q,   state_d;
  logic [3:0] cnt_q,     cnt_d;
  logic [7:0] gnt_q,     gnt_d;
  logic [2:0] gnt_id_q,  gnt_id_d;
  logic       timeout_q, timeout_d;

  logic       win_vld;
  logic [2:0] win_id;

  assign win_vld = |bus.req;

`ifdef ROUND_ROBIN_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;

  // Walk from lowest priority (the pointer itself, k=8) to highest (ptr-1,
  // k=1); the last hit in the loop is therefore the highest-priority requester.
  always_comb begin
    win_id = rr_ptr_q;
    for (int k = 8; k >= 1; k--) begin
      if (bus.req[rr_ptr_q - 3'(k)]) begin
        win_id = rr_ptr_q - 3'(k);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && win_vld) begin
      rr_ptr_d = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 3'd7;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Fixed priority: ascending scan, so the highest set index is kept.
  always_comb begin
    win_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req[i]) begin
        win_id = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gnt_d    = 8'b1 << win_id;
          gnt_id_d = win_id;
          cnt_d    = 4'd1;
          state_d  = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // Owner release is checked before the hold limit so that a done on
        // the final allowed cycle never produces a timeout pulse.
        if (bus.done || !bus.req[gnt_id_q]) begin
          gnt_d   = 8'h00;
          state_d = ST_GAP;
        end else if (cnt_q == C_HOLD_MAX) begin
          gnt_d     = 8'h00;
          timeout_d = 1'b1;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_GAP: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d   = 8'h00;
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      gnt_q     <= 8'h00;
      gnt_id_q  <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = (state_q == ST_GRANT);
  assign bus.timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_8_ctrl
// Description : Self-checking bench for arbiter_8_ctrl (HOLD_MAX=4). Directed
//               vector table, reset/async-reset sequences, then randomized
//               traffic compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_8_ctrl;

  localparam int HOLD = 4;

  logic clk;
  logic rst_n;

  arbiter_8_ctrl_if bus ();

  arbiter_8_ctrl #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic       to;
  } vec_t;

  vec_t vecs[$];

  // ---------------- behavioural model ----------------
  int       m_owner;   // -1 when nobody holds the resource
  int       m_len;     // cycles the owner has held it
  bit       m_gap;     // dead cycle in progress
  bit       m_to;
  int       m_id;
  int       m_ptr;

  task automatic model_reset();
    m_owner = -1; m_len = 0; m_gap = 0; m_to = 0; m_id = 0; m_ptr = 7;
  endtask

  function automatic int pick(input logic [7:0] r);
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (m_ptr - k + 8) % 8;
      if (r[idx]) return idx;
    end
`else
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic d);
    m_to = 0;
    if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r);
        m_id    = m_owner;
        m_ptr   = m_owner;
        m_len   = 1;
      end
    end else begin
      if (d || !r[m_owner]) begin
        m_owner = -1; m_gap = 1;
      end else if (m_len == HOLD) begin
        m_owner = -1; m_gap = 1; m_to = 1;
      end else begin
        m_len++;
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare_model(input string name);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check({name, ".gnt"},     bus.gnt,              eg);
    check({name, ".gnt_id"},  {5'd0, bus.gnt_id},   8'(m_id));
    check({name, ".busy"},    {7'd0, bus.busy},     {7'd0, (m_owner >= 0)});
    check({name, ".timeout"}, {7'd0, bus.timeout},  {7'd0, m_to});
  endtask

  task automatic drive_step(input logic [7:0] r, input logic d);
    bus.req  = r;
    bus.done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] r, input logic d, input logic [7:0] g,
                      input logic [2:0] id, input logic b, input logic t);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.id = id; v.busy = b; v.to = t;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] r;

    // ---- vector table (starts in IDLE, pointer at reset value) ----
`ifdef ROUND_ROBIN_EN
    begin
      int seq [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
      foreach (seq[i]) begin
        push(8'hFF, 1'b1, 8'(1 << seq[i]), 3'(seq[i]), 1'b1, 1'b0);
        push(8'hFF, 1'b1, 8'h00,           3'(seq[i]), 1'b0, 1'b0);
        push(8'hFF, 1'b1, 8'h00,           3'(seq[i]), 1'b0, 1'b0);
      end
    end
`else
    push(8'h2A, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);  // priority: 5 of {5,3,1}
    push(8'h2A, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0);  // done -> GAP
    push(8'h2A, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);  // IDLE
    push(8'h2A, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);  // 5 again
    push(8'h0A, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);  // req[5] drops -> GAP
    push(8'h0A, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0);
    push(8'h0A, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);  // 3 wins
    push(8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);
    push(8'h04, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0);  // GAP ignores req
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // hold cycle 1
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // 2
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // 3
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // 4
    push(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1);  // limit -> timeout
    push(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // hold cycle 1
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
    push(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);  // 4th cycle
    push(8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0);  // done beats limit
    push(8'h02, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0);
    push(8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);  // owner 1
    push(8'h82, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);  // 7 cannot preempt
    push(8'h82, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0);  // release
    push(8'h82, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
    push(8'h82, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);  // 7 two edges later
    push(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);
    push(8'h00, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);
`endif

    // ---- reset with all requests asserted ----
    rst_n    = 1'b0;
    bus.req  = 8'hFF;
    bus.done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.gnt",     bus.gnt,                  8'h00);
    check("rst.gnt_id",  {5'd0, bus.gnt_id},       8'h00);
    check("rst.busy",    {7'd0, bus.busy},         8'h00);
    check("rst.timeout", {7'd0, bus.timeout},      8'h00);

    rst_n = 1'b1;
    drive_step(8'hFF, 1'b0);
`ifndef ROUND_ROBIN_EN
    check("rst_release.gnt80", bus.gnt, 8'h80);
`endif
    compare_model("rst_release");

    // ---- asynchronous reset in the middle of a grant ----
    drive_step(8'hFF, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst.gnt",  bus.gnt,          8'h00);
    check("async_rst.busy", {7'd0, bus.busy}, 8'h00);
    check("async_rst.id",   {5'd0, bus.gnt_id}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_step(8'h00, 1'b0);
    compare_model("post_rst_idle");

    // ---- table ----
    foreach (vecs[i]) begin
      drive_step(vecs[i].req, vecs[i].done);
      check($sformatf("vec%0d.gnt", i),     bus.gnt,              vecs[i].gnt);
      check($sformatf("vec%0d.gnt_id", i),  {5'd0, bus.gnt_id},   {5'd0, vecs[i].id});
      check($sformatf("vec%0d.busy", i),    {7'd0, bus.busy},     {7'd0, vecs[i].busy});
      check($sformatf("vec%0d.timeout", i), {7'd0, bus.timeout},  {7'd0, vecs[i].to});
    end

    // ---- randomized traffic against the model ----
    r = 8'h00;
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 5))
        0:       r = 8'($urandom);
        1:       r = 8'(1 << $urandom_range(0, 7));
        2:       r = 8'h00;
        3:       r = r | 8'(1 << $urandom_range(0, 7));
        default: r = r;
      endcase
      drive_step(r, ($urandom_range(0, 4) == 0));
      compare_model($sformatf("rand%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
